// File: rtl/ej1_pkg.sv
// ej1_pkg: shared types and default constants for the ej1 input conditioning slice.
`default_nettype none

package ej1_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_e;

  localparam int EJ1_DEB_CYCLES = 8;
  localparam int EJ1_CNT_W      = 4;

endpackage

`default_nettype wire

// File: rtl/ej1_debounce_ch.sv
// ej1_debounce_ch: two-flop synchronizer, tick-qualified debounce counter and
// registered rise/fall pulses for one switch channel.
`default_nettype none

module ej1_debounce_ch
  import ej1_pkg::*;
#(
  parameter int DEB_CYCLES = EJ1_DEB_CYCLES,
  parameter int CNT_W      = EJ1_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sy1_q, sy_q;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1_q   <= 1'b0;
      sy_q    <= 1'b0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      sy1_q   <= raw;
      sy_q    <= sy1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Counter is non-zero only in CHECK, so the terminal test is qualified by state.
  always_comb begin
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sy_q == out_q) begin
      cnt_d   = '0;
      state_d = STABLE;
    end else if (!en) begin
      cnt_d   = cnt_q;
      state_d = state_q;
    end else if (state_q == CHECK && cnt_q == CNT_MAX) begin
      out_d   = sy_q;
      rise_d  = sy_q;
      fall_d  = ~sy_q;
      cnt_d   = '0;
      state_d = STABLE;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = CHECK;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

`default_nettype wire

// File: rtl/ej1_input_cond.sv
// ej1_input_cond: synchronizes and debounces the raw I and S switches into clean
// levels and one-cycle edge pulses for the ej1 FSM.
`default_nettype none

module ej1_input_cond
  import ej1_pkg::*;
#(
  parameter int DEB_CYCLES = EJ1_DEB_CYCLES,
  parameter int CNT_W      = EJ1_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i_raw,
  input  logic s_raw,
  output logic I,
  output logic S,
  output logic i_rise,
  output logic i_fall,
  output logic s_rise,
  output logic s_fall
);

  ej1_debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch_i (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .raw   (i_raw),
    .out   (I),
    .rise  (i_rise),
    .fall  (i_fall)
  );

  ej1_debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch_s (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .raw   (s_raw),
    .out   (S),
    .rise  (s_rise),
    .fall  (s_fall)
  );

endmodule

`default_nettype wire

// File: tb/tb_ej1_input_cond.sv
// tb_ej1_input_cond: table-driven, per-edge scoreboard bench for ej1_input_cond.
`default_nettype none

module tb_ej1_input_cond;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic i_raw = 1'b0;
  logic s_raw = 1'b0;
  logic I, S, i_rise, i_fall, s_rise, s_fall;

  int checks = 0;
  int errors = 0;

  // Expected vector layout: {I, S, i_rise, i_fall, s_rise, s_fall}
  logic [5:0] exp_q[$];
  string      name_q[$];
  logic       cur_i = 1'b0;
  logic       cur_s = 1'b0;

  typedef struct {
    logic       ir;
    logic       sr;
    logic       en;
    int         n;
    logic [5:0] exp;
    string      name;
  } vec_t;

  ej1_input_cond dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .i_raw  (i_raw),
    .s_raw  (s_raw),
    .I      (I),
    .S      (S),
    .i_rise (i_rise),
    .i_fall (i_fall),
    .s_rise (s_rise),
    .s_fall (s_fall)
  );

  always #5 clk = ~clk;

  task automatic compare_now();
    logic [5:0] e;
    logic [5:0] got;
    string      nm;
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    got = {I, S, i_rise, i_fall, s_rise, s_fall};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got {I,S,ir,if,sr,sf}=%b expected %b at %0t", nm, got, e, $time);
    end
  endtask

  task automatic check_edge();
    @(posedge clk);
    #1;
    compare_now();
  endtask

  // Intermediate edges must hold the current levels with no pulses; the last edge takes v.exp.
  task automatic apply(input vec_t v);
    i_raw = v.ir;
    s_raw = v.sr;
    en    = v.en;
    for (int j = 0; j < v.n; j++) begin
      if (j == v.n - 1) exp_q.push_back(v.exp);
      else              exp_q.push_back({cur_i, cur_s, 4'b0000});
      name_q.push_back(v.name);
      check_edge();
    end
    cur_i = v.exp[5];
    cur_s = v.exp[4];
  endtask

  vec_t tbl[$];

  initial begin
    int nt;
    int rise_e;
    logic tk;

    tbl.push_back('{1'b0, 1'b0, 1'b1, 9,  6'b11_0000, "fall_wait"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  6'b00_0101, "fall_both"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 3,  6'b00_0000, "fall_idle"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9,  6'b00_0000, "step_wait"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1,  6'b10_1000, "step_rise"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 2,  6'b10_0000, "step_hold"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 9,  6'b10_0000, "ifall_wait"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  6'b00_0100, "ifall"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2,  6'b00_0000, "ifall_hold"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 5,  6'b00_0000, "bounce_hi"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2,  6'b00_0000, "bounce_lo"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9,  6'b00_0000, "bounce_wait"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1,  6'b10_1000, "bounce_rise"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 3,  6'b10_0000, "bounce_hold"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 10, 6'b00_0100, "bounce_fall"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2,  6'b00_0000, "bounce_idle"});
    // S high for one tick short of the threshold, then exactly at it.
    tbl.push_back('{1'b0, 1'b1, 1'b1, 7,  6'b00_0000, "s_short"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 12, 6'b00_0000, "s_short_after"});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8,  6'b00_0000, "s_exact_hi"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  6'b00_0000, "s_exact_wait"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  6'b01_0010, "s_exact_rise"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 7,  6'b01_0000, "s_exact_hold"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1,  6'b00_0001, "s_exact_fall"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2,  6'b00_0000, "s_exact_idle"});

    // Reset with both switches already high.
    i_raw = 1'b1;
    s_raw = 1'b1;
    en    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(6'b0); name_q.push_back("reset_async");
    compare_now();
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(6'b0); name_q.push_back("reset_hold");
      check_edge();
    end
    rst_n = 1'b1;
    // Raw is already high at release, so the first edge after release is the change edge.
    apply('{1'b1, 1'b1, 1'b1, 9, 6'b00_0000, "rel_wait"});
    apply('{1'b1, 1'b1, 1'b1, 1, 6'b11_1010, "rel_rise"});
    apply('{1'b1, 1'b1, 1'b1, 1, 6'b11_0000, "rel_hold"});

    foreach (tbl[k]) apply(tbl[k]);

    // Tick gating: en every 4th edge, with a long frozen window in the middle.
    s_raw  = 1'b1;
    nt     = 0;
    rise_e = -1;
    for (int e = 1; e <= 64; e++) begin
      tk = ((e % 4) == 0) && !(e > 12 && e <= 40);
      en = tk;
      if (tk && e >= 3 && rise_e < 0) begin
        nt++;
        if (nt == 8) rise_e = e;
      end
      exp_q.push_back({1'b0, (rise_e > 0), 2'b00, (rise_e == e), 1'b0});
      name_q.push_back("tick_gate");
      check_edge();
    end
    if (rise_e != 60) begin
      errors++;
      $display("FAIL tick_model: rise edge %0d required 60", rise_e);
    end
    cur_s = 1'b1;
    apply('{1'b0, 1'b0, 1'b1, 10, 6'b00_0001, "tick_sfall"});
    apply('{1'b0, 1'b0, 1'b1, 2,  6'b00_0000, "tick_idle"});

    // Reset in the middle of an I count.
    apply('{1'b1, 1'b0, 1'b1, 6, 6'b00_0000, "mid_count"});
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(6'b0); name_q.push_back("mid_reset");
      check_edge();
    end
    rst_n = 1'b1;
    apply('{1'b1, 1'b0, 1'b1, 9, 6'b00_0000, "mid_rel_wait"});
    apply('{1'b1, 1'b0, 1'b1, 1, 6'b10_1000, "mid_rel_rise"});
    apply('{1'b1, 1'b0, 1'b1, 2, 6'b10_0000, "mid_rel_hold"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ej1_input_cond.md
Name: ej1_input_cond

Overview:
- Upstream conditioning stage for the ej1 sequential block.
- Takes the two raw, asynchronous, bouncing switch inputs (I, S) and synchronizes them into the clk domain.
- Debounces each channel with a tick-qualified counter. Delivers clean registered levels I and S, plus one-cycle edge pulses for the bench and status logic.
- The outputs drive the I and S inputs of the ej1 FSM directly.

Parameters:
- DEB_CYCLES, 8: number of consecutive qualifying en ticks a changed input must hold before the output follows. Legal range 2..2**CNT_W.
- CNT_W, 4: debounce counter width. Must satisfy DEB_CYCLES-1 < 2**CNT_W.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample tick; debounce counters advance only when high. Tie high for a per-clock count.
- i_raw  input  1  raw I switch, asynchronous to clk.
- s_raw  input  1  raw S switch, asynchronous to clk.
- I  output  1  debounced I level.
- S  output  1  debounced S level.
- i_rise  output  1  one-cycle pulse on the I 0->1 transition.
- i_fall  output  1  one-cycle pulse on the I 1->0 transition.
- s_rise  output  1  one-cycle pulse on the S 0->1 transition.
- s_fall  output  1  one-cycle pulse on the S 1->0 transition.

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, counters, I, S and all pulses go to 0; state is STABLE. All outputs read 0 during reset.
- After reset release, behaviour starts on the next rising clk edge.
- Channels are fully independent; identical logic per channel. Below, raw = channel input, sy = second sync flop, out = debounced output.
- Synchronizer: two flops, raw -> sy1 -> sy. No logic between them.
- FSM states:
  - STABLE: sy == out, cnt held at 0.
  - CHECK: sy != out, counting.
- Per edge, evaluated in this order:
  1. If sy == out: cnt <= 0, state <= STABLE. A bounce back cancels the check and no pulse is produced.
  2. Else if en == 0: hold cnt and state.
  3. Else if cnt == DEB_CYCLES-1: out <= sy, cnt <= 0, state <= STABLE, and the matching rise/fall pulse goes high for exactly this one cycle. The pulse is registered and coincident with the out change.
  4. Else: cnt <= cnt+1, state <= CHECK.
- Latency with en tied high: raw changes before edge k; sy updates at edge k+1; out and pulse update at edge k+1+DEB_CYCLES. With the default, this is 9 clocks.
- Pulses are never high on two consecutive cycles for the same channel. Rise and fall are never high together.
- Counter never wraps. It saturates logically via rule 3 and is cleared by rule 1.
- Any input glitch shorter than DEB_CYCLES ticks (measured at sy) produces no output change.
- Simultaneous changes on both channels are processed in parallel. No arbitration and no ordering between I and S.
- Reset asserted mid-count aborts the count. out returns to 0 and the pending transition is lost. If raw is still high after release, a fresh full debounce is required.

Decomposition:
- Shared package ej1_pkg:
  - state enum (STABLE, CHECK);
  - default constants EJ1_DEB_CYCLES = 8 and EJ1_CNT_W = 4.
- Sub-module ej1_debounce_ch:
  - contains synchronizer, counter, FSM and pulse logic for one channel;
  - ports: clk, rst_n, en, raw, out, rise, fall;
  - instantiated twice in ej1_input_cond.

Test Plan:
- Reset: hold rst_n=0 with i_raw=s_raw=1 -> I=S=0, all pulses 0. Release, en=1 -> I rises at edge 9 after release, i_rise high for that single cycle.
- Clean step: en=1, i_raw 0->1 before edge k -> I=1 and i_rise=1 after edge k+9, i_rise=0 after edge k+10. S and s_* stay 0 throughout.
- Bounce reject: i_raw high for 5 clocks, low for 2, then high steady -> I stays 0 until 9 edges after the final rise. Exactly one i_rise.
- Tick gating: en pulsed every 4th clock, s_raw 0->1 -> S rises only after 8 en ticks, i.e. about 32 clocks plus sync. Holding en=0 keeps the counter frozen, with no S change.
- Simultaneous / fall: i_raw and s_raw both 1->0 on the same edge from I=S=1 -> I and S fall on the same edge. i_fall and s_fall pulse together; no rise pulses.
- Reset mid-count: i_raw 0->1, assert rst_n after 4 counting edges, release -> I=0 through reset, then a full 9-edge delay before I=1.
